// File: rtl/cfs_algn_pkg.sv
// Shared types and width helpers for the aligner RX/TX path.
package cfs_algn_pkg;

  function automatic int algn_offset_width(input int dw);
    return (dw <= 8) ? 1 : $clog2(dw / 8);
  endfunction

  function automatic int algn_size_width(input int dw);
    return $clog2(dw / 8) + 1;
  endfunction

  function automatic int algn_fifo_width(input int dw);
    return dw + algn_offset_width(dw) + algn_size_width(dw);
  endfunction

  localparam int ALGN_DATA_WIDTH_DEF   = 32;
  localparam int ALGN_OFFSET_WIDTH_DEF = algn_offset_width(ALGN_DATA_WIDTH_DEF);
  localparam int ALGN_SIZE_WIDTH_DEF   = algn_size_width(ALGN_DATA_WIDTH_DEF);

  // FIFO entry at the default MD width; size sits in the MSBs, data in the LSBs.
  typedef struct packed {
    logic [ALGN_SIZE_WIDTH_DEF-1:0]   size;
    logic [ALGN_OFFSET_WIDTH_DEF-1:0] offset;
    logic [ALGN_DATA_WIDTH_DEF-1:0]   data;
  } cfs_algn_fifo_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } cfs_rx_state_t;

endpackage

// File: rtl/cfs_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
module cfs_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? WIDTH'(1) : '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cfs_rx_ctrl.sv
// MD RX front end: checks each transfer, pushes legal ones into the RX FIFO
// as {size, offset, data}, rejects and counts illegal ones.
module cfs_rx_ctrl
  import cfs_algn_pkg::*;
#(
  parameter  int ALGN_DATA_WIDTH   = 32,
  parameter  int CNT_DROP_WIDTH    = 8,
  localparam int ALGN_OFFSET_WIDTH = algn_offset_width(ALGN_DATA_WIDTH),
  localparam int ALGN_SIZE_WIDTH   = algn_size_width(ALGN_DATA_WIDTH),
  localparam int FIFO_WIDTH        = algn_fifo_width(ALGN_DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
  input  logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset,
  input  logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size,
  output logic                         md_rx_ready,
  output logic                         md_rx_err,
  output logic                         push_valid,
  output logic [FIFO_WIDTH-1:0]        push_data,
  input  logic                         push_ready,
  output logic [CNT_DROP_WIDTH-1:0]    cnt_drop,
  input  logic                         cnt_drop_clr,
  output logic                         drop_pulse
);

  localparam logic [ALGN_SIZE_WIDTH:0] LP_BYTES = (ALGN_SIZE_WIDTH + 1)'(ALGN_DATA_WIDTH / 8);

  cfs_rx_state_t          r_state;
  cfs_rx_state_t          w_state_nxt;
  logic                   r_ready;
  logic                   r_err;
  logic                   r_drop_pulse;
  logic                   r_push_vld;
  logic [FIFO_WIDTH-1:0]  r_push_dat;
  logic [ALGN_SIZE_WIDTH:0] w_sum;
  logic                   w_legal;
  logic                   w_buf_free;
  logic                   w_accept;
  logic                   w_drop;

  // One extra bit so offset + size cannot wrap back into the legal range.
  assign w_sum      = (ALGN_SIZE_WIDTH + 1)'(md_rx_offset) + (ALGN_SIZE_WIDTH + 1)'(md_rx_size);
  assign w_legal    = (md_rx_size != '0) && (w_sum <= LP_BYTES);
  assign w_buf_free = !r_push_vld || push_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (md_rx_valid) begin
          if (!w_legal) begin
            w_drop      = 1'b1;
            w_state_nxt = ST_RESP;
          end else if (w_buf_free) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_push_vld   <= 1'b0;
      r_push_dat   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_accept || w_drop;
      r_err        <= w_drop;
      r_drop_pulse <= w_drop;
      // A capture on the pop edge reloads the buffer, so push_valid stays high.
      if (w_accept) begin
        r_push_vld <= 1'b1;
        r_push_dat <= {md_rx_size, md_rx_offset, md_rx_data};
      end else if (push_ready) begin
        r_push_vld <= 1'b0;
      end
    end
  end

  cfs_sat_cnt #(
    .WIDTH (CNT_DROP_WIDTH)
  ) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (cnt_drop_clr),
    .i_inc   (w_drop),
    .o_cnt   (cnt_drop)
  );

  assign md_rx_ready = r_ready;
  assign md_rx_err   = r_err;
  assign drop_pulse  = r_drop_pulse;
  assign push_valid  = r_push_vld;
  assign push_data   = r_push_dat;

endmodule

// File: doc/cfs_rx_ctrl.md
Name: cfs_rx_ctrl

Overview:
- Upstream neighbour of the alignment controller.
- Accepts unaligned transfers from the MD RX slave interface and checks that each one is legal.
- Packs each legal transfer as {size, offset, data} and pushes it into the RX FIFO, which the alignment controller pops.
- Rejects illegal transfers with an error response, drops them, and counts them in a saturating drop counter.

Parameters:
- ALGN_DATA_WIDTH, 32: MD data width in bits; power of 2, >= 8.
- CNT_DROP_WIDTH, 8: width of the drop counter.
- ALGN_OFFSET_WIDTH (localparam): ALGN_DATA_WIDTH<=8 ? 1 : $clog2(ALGN_DATA_WIDTH/8).
- ALGN_SIZE_WIDTH (localparam): $clog2(ALGN_DATA_WIDTH/8)+1.
- FIFO_WIDTH (localparam): ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  asynchronous reset, active-low.
- md_rx_valid  in  1  MD master has a transfer; held until md_rx_ready is seen high.
- md_rx_data  in  ALGN_DATA_WIDTH  unaligned data bytes.
- md_rx_offset  in  ALGN_OFFSET_WIDTH  byte offset of the first valid byte.
- md_rx_size  in  ALGN_SIZE_WIDTH  number of valid bytes.
- md_rx_ready  out  1  registered; one-cycle response pulse.
- md_rx_err  out  1  qualified by md_rx_ready; 1 = transfer rejected.
- push_valid  out  1  RX FIFO push request.
- push_data  out  FIFO_WIDTH  packed as {size, offset, data}; size in MSBs, data in LSBs.
- push_ready  in  1  RX FIFO not full.
- cnt_drop  out  CNT_DROP_WIDTH  number of rejected transfers; saturating.
- cnt_drop_clr  in  1  synchronous clear pulse for cnt_drop.
- drop_pulse  out  1  one-cycle pulse per rejected transfer; used as interrupt source.

Behaviour:
- Reset values: md_rx_ready=0, md_rx_err=0, push_valid=0, push_data=0, cnt_drop=0, drop_pulse=0, FSM=IDLE.
- Legality: transfer is legal iff md_rx_size!=0 and md_rx_offset + md_rx_size <= ALGN_DATA_WIDTH/8.
  - The sum is evaluated at ALGN_SIZE_WIDTH+1 bits; no wrap.
- FSM states: IDLE and RESP.
- IDLE, md_rx_valid=1, illegal:
  - next cycle: md_rx_ready=1, md_rx_err=1, drop_pulse=1; cnt_drop increments, saturating at all-ones; go to RESP.
  - Push buffer is untouched.
- IDLE, md_rx_valid=1, legal, push buffer free:
  - Buffer is free when push_valid=0, or push_valid&push_ready in this same cycle.
  - Capture {size, offset, data} into push_data; push_valid=1 next cycle.
  - Next cycle: md_rx_ready=1, md_rx_err=0; go to RESP.
- IDLE, md_rx_valid=1, legal, buffer occupied and not draining:
  - Stall: md_rx_ready stays 0; stay in IDLE; re-evaluate every cycle.
- IDLE, md_rx_valid=0: stay in IDLE; outputs idle.
- RESP: md_rx_ready=1 for exactly this one cycle; the MD transfer completes here. Next state is unconditionally IDLE. md_rx_valid is not sampled in RESP.
- Latency and throughput:
  - valid sampled at edge N -> ready/err and push_valid high in cycle N+1.
  - Maximum rate is 1 transfer per 2 cycles.
- Push buffer (single entry):
  - push_valid drops after the push_valid&push_ready edge unless reloaded on that same edge.
  - push_data is stable while push_valid=1 and push_ready=0.
  - push_data is not cleared on pop.
- Simultaneous events:
  - Pop and new capture on the same edge: the new entry is loaded; push_valid stays 1.
  - cnt_drop_clr together with an increment: cnt_drop=1.
  - cnt_drop_clr alone: cnt_drop=0.
- Reset mid-operation: all state clears asynchronously. An in-flight MD transfer gets no response and an unpopped push entry is lost; the master re-issues after reset.
- Protocol assumption: MD inputs are stable while md_rx_valid=1 and md_rx_ready=0; the bench checks this with an assertion.

Decomposition:
- Shared package cfs_algn_pkg holds:
  - the width localparam functions (offset, size, FIFO width);
  - the packed struct typedef cfs_algn_fifo_entry_t {size, offset, data}, also used by the alignment controller;
  - the FSM enum cfs_rx_state_t.
- One natural sub-module: cfs_sat_cnt, a parameterized saturating counter with clear and increment, reusable for TX-side counters.
- The legality check stays inline.

Test Plan:
- Legal transfer (width 32): size=2, offset=1, data=0xAABBCCDD, push_ready=1 -> next cycle ready=1, err=0, push_valid=1, push_data={2,1,0xAABBCCDD}; one push.
- Illegal size=0 -> ready=1, err=1, drop_pulse=1, cnt_drop 0->1, no push. Then offset=3, size=2 -> err=1, cnt_drop=2.
- Backpressure: push_ready=0 with an entry held, new legal transfer -> ready stays 0 for 5 cycles; raise push_ready -> pop and reload on the same edge; ready=1 the next cycle; push_data is the new entry.
- Back-to-back legal transfers with valid held high -> ready pulses every 2nd cycle; pushes in order; no duplicate capture in RESP.
- Saturation: 256 illegal transfers with CNT_DROP_WIDTH=8 -> cnt_drop=255, stays 255. Then clear together with a drop -> cnt_drop=1.
- Assert reset_n in the cycle after valid is sampled (before ready) -> ready, push_valid, cnt_drop all 0 asynchronously. After release, a re-issued transfer completes normally.
